// File: rtl/mem_lsu.sv
// -----------------------------------------------------------------------------
// mem_lsu: memory-access stage of the five-stage RV32I pipeline.
//
// Executes loads and stores over a single-outstanding req/ack data bus. It
// stalls the pipeline while an access is in flight, builds lane-replicated
// store data and byte enables, and aligns and extends load data. It flags
// misaligned accesses and bus timeouts. Non-memory ops pass straight through
// to writeback combinationally.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   mem_reg_*       destination reg / write enable / ALU result from EX/MEM
//   mem_op          0 NOP, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 SB, 7 SH, 8 SW
//   mem_addr        effective byte address
//   mem_sdata       store data (rs2)
//   wb_reg_*        writeback outputs to MEM/WB
//   stall_req       pipeline stall request
//   misalign        misaligned-access pulse
//   bus_err         bus-timeout pulse
//   dbus_*          registered request side of the data bus
//   dbus_ack        slave completion pulse
//   dbus_rdata      read word, valid with dbus_ack
// -----------------------------------------------------------------------------
module mem_lsu #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  mem_reg_waddr,
   input  logic        mem_reg_we,
   input  logic [31:0] mem_reg_wdata,
   input  logic [3:0]  mem_op,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_sdata,
   output logic [4:0]  wb_reg_waddr,
   output logic        wb_reg_we,
   output logic [31:0] wb_reg_wdata,
   output logic        stall_req,
   output logic        misalign,
   output logic        bus_err,
   output logic        dbus_req,
   output logic        dbus_we,
   output logic [31:0] dbus_addr,
   output logic [3:0]  dbus_be,
   output logic [31:0] dbus_wdata,
   input  logic        dbus_ack,
   input  logic [31:0] dbus_rdata
);

   localparam logic [3:0] OpNop = 4'd0;
   localparam logic [3:0] OpLb  = 4'd1;
   localparam logic [3:0] OpLh  = 4'd2;
   localparam logic [3:0] OpLw  = 4'd3;
   localparam logic [3:0] OpLbu = 4'd4;
   localparam logic [3:0] OpLhu = 4'd5;
   localparam logic [3:0] OpSb  = 4'd6;
   localparam logic [3:0] OpSh  = 4'd7;
   localparam logic [3:0] OpSw  = 4'd8;

   // Last BUSY count before giving up on the ack.
   localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

   state_e state_q, state_d;

   logic [7:0]  cnt_q, cnt_d;
   logic        err_q, err_d;
   logic [31:0] lbuf_q, lbuf_d;
   logic [3:0]  op_q, op_d;
   logic [1:0]  lane_q, lane_d;

   logic        dbus_req_q, dbus_req_d;
   logic        dbus_we_q, dbus_we_d;
   logic [31:0] dbus_addr_q, dbus_addr_d;
   logic [3:0]  dbus_be_q, dbus_be_d;
   logic [31:0] dbus_wdata_q, dbus_wdata_d;

   // ---------------------------------------------------------------------------
   // Decode of the incoming op
   // ---------------------------------------------------------------------------
   logic is_load, is_store, misaligned, access;

   always_comb begin
      is_load    = (mem_op >= OpLb) && (mem_op <= OpLhu);
      is_store   = (mem_op >= OpSb) && (mem_op <= OpSw);
      misaligned = ((mem_op == OpLh) || (mem_op == OpLhu) || (mem_op == OpSh)) && mem_addr[0];
      misaligned = misaligned ||
                   (((mem_op == OpLw) || (mem_op == OpSw)) && (mem_addr[1:0] != 2'b00));
      access     = (is_load || is_store) && !misaligned;
   end

   // Store byte enables and lane-replicated write data.
   logic [3:0]  st_be;
   logic [31:0] st_wdata;

   always_comb begin
      st_be    = 4'b1111;
      st_wdata = mem_sdata;
      case (mem_op)
         OpSb: begin
            st_be    = 4'b0001 << mem_addr[1:0];
            st_wdata = {4{mem_sdata[7:0]}};
         end
         OpSh: begin
            st_be    = mem_addr[1] ? 4'b1100 : 4'b0011;
            st_wdata = {2{mem_sdata[15:0]}};
         end
         default: begin
            st_be    = 4'b1111;
            st_wdata = mem_sdata;
         end
      endcase
   end

   // Load extraction from the captured word, using the op and lane latched
   // when the access was launched.
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_ext;
   logic        done_store;

   always_comb begin
      unique case (lane_q)
         2'd0: ld_byte = lbuf_q[7:0];
         2'd1: ld_byte = lbuf_q[15:8];
         2'd2: ld_byte = lbuf_q[23:16];
         2'd3: ld_byte = lbuf_q[31:24];
         default: ld_byte = lbuf_q[7:0];
      endcase
      ld_half = lane_q[1] ? lbuf_q[31:16] : lbuf_q[15:0];
      case (op_q)
         OpLb:    ld_ext = {{24{ld_byte[7]}}, ld_byte};
         OpLbu:   ld_ext = {24'h0, ld_byte};
         OpLh:    ld_ext = {{16{ld_half[15]}}, ld_half};
         OpLhu:   ld_ext = {16'h0, ld_half};
         default: ld_ext = lbuf_q;
      endcase
      done_store = (op_q == OpSb) || (op_q == OpSh) || (op_q == OpSw);
   end

   // ---------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: next state
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: if (access) state_d = StBusy;
         StBusy: if (dbus_ack || (cnt_q == CntLast)) state_d = StDone;
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // ---------------------------------------------------------------------------
   // FSM: combinational outputs
   // ---------------------------------------------------------------------------
   always_comb begin
      wb_reg_waddr = mem_reg_waddr;
      wb_reg_we    = mem_reg_we;
      wb_reg_wdata = mem_reg_wdata;
      stall_req    = 1'b0;
      misalign     = 1'b0;
      bus_err      = 1'b0;
      if (rst) begin
         wb_reg_waddr = 5'd0;
         wb_reg_we    = 1'b0;
         wb_reg_wdata = 32'd0;
      end else begin
         case (state_q)
            StIdle: begin
               if (misaligned) begin
                  misalign  = 1'b1;
                  wb_reg_we = 1'b0;
               end else if (access) begin
                  stall_req = 1'b1;
                  wb_reg_we = 1'b0;
               end
            end
            StBusy: begin
               stall_req = 1'b1;
               wb_reg_we = 1'b0;
            end
            StDone: begin
               if (err_q) begin
                  bus_err   = 1'b1;
                  wb_reg_we = 1'b0;
               end else if (done_store) begin
                  wb_reg_we = 1'b0;
               end else begin
                  wb_reg_wdata = ld_ext;
               end
            end
            default: begin
               wb_reg_we = 1'b0;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Datapath registers: bus request, timeout counter, load buffer
   // ---------------------------------------------------------------------------
   always_comb begin
      cnt_d        = cnt_q;
      err_d        = err_q;
      lbuf_d       = lbuf_q;
      op_d         = op_q;
      lane_d       = lane_q;
      dbus_req_d   = dbus_req_q;
      dbus_we_d    = dbus_we_q;
      dbus_addr_d  = dbus_addr_q;
      dbus_be_d    = dbus_be_q;
      dbus_wdata_d = dbus_wdata_q;
      case (state_q)
         StIdle: begin
            if (access) begin
               dbus_req_d   = 1'b1;
               dbus_we_d    = is_store;
               dbus_addr_d  = {mem_addr[31:2], 2'b00};
               dbus_be_d    = is_store ? st_be : 4'b1111;
               dbus_wdata_d = is_store ? st_wdata : 32'd0;
               cnt_d        = 8'd0;
               err_d        = 1'b0;
               op_d         = mem_op;
               lane_d       = mem_addr[1:0];
            end
         end
         StBusy: begin
            // An ack on the final count still wins over the timeout.
            if (dbus_ack) begin
               dbus_req_d = 1'b0;
               lbuf_d     = dbus_rdata;
            end else if (cnt_q == CntLast) begin
               dbus_req_d = 1'b0;
               err_d      = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         StDone: begin
            err_d = 1'b0;
         end
         default: begin
            dbus_req_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q        <= 8'd0;
         err_q        <= 1'b0;
         lbuf_q       <= 32'd0;
         op_q         <= OpNop;
         lane_q       <= 2'd0;
         dbus_req_q   <= 1'b0;
         dbus_we_q    <= 1'b0;
         dbus_addr_q  <= 32'd0;
         dbus_be_q    <= 4'd0;
         dbus_wdata_q <= 32'd0;
      end else begin
         cnt_q        <= cnt_d;
         err_q        <= err_d;
         lbuf_q       <= lbuf_d;
         op_q         <= op_d;
         lane_q       <= lane_d;
         dbus_req_q   <= dbus_req_d;
         dbus_we_q    <= dbus_we_d;
         dbus_addr_q  <= dbus_addr_d;
         dbus_be_q    <= dbus_be_d;
         dbus_wdata_q <= dbus_wdata_d;
      end
   end

   assign dbus_req   = dbus_req_q;
   assign dbus_we    = dbus_we_q;
   assign dbus_addr  = dbus_addr_q;
   assign dbus_be    = dbus_be_q;
   assign dbus_wdata = dbus_wdata_q;

endmodule

// File: tb/tb_mem_lsu.sv
// -----------------------------------------------------------------------------
// tb_mem_lsu: directed bench for mem_lsu. Each op is described once; a small
// transaction model derives the per-cycle expected outputs, and one compare
// process at the falling edge checks the DUT against them. A few literal
// expectations pin the model.
// -----------------------------------------------------------------------------
module tb_mem_lsu;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  mem_reg_waddr;
   logic        mem_reg_we;
   logic [31:0] mem_reg_wdata;
   logic [3:0]  mem_op;
   logic [31:0] mem_addr;
   logic [31:0] mem_sdata;
   logic [4:0]  wb_reg_waddr;
   logic        wb_reg_we;
   logic [31:0] wb_reg_wdata;
   logic        stall_req;
   logic        misalign;
   logic        bus_err;
   logic        dbus_req;
   logic        dbus_we;
   logic [31:0] dbus_addr;
   logic [3:0]  dbus_be;
   logic [31:0] dbus_wdata;
   logic        dbus_ack;
   logic [31:0] dbus_rdata;

   mem_lsu #(.TIMEOUT(TO)) dut (
      .clk          (clk),
      .rst          (rst),
      .mem_reg_waddr(mem_reg_waddr),
      .mem_reg_we   (mem_reg_we),
      .mem_reg_wdata(mem_reg_wdata),
      .mem_op       (mem_op),
      .mem_addr     (mem_addr),
      .mem_sdata    (mem_sdata),
      .wb_reg_waddr (wb_reg_waddr),
      .wb_reg_we    (wb_reg_we),
      .wb_reg_wdata (wb_reg_wdata),
      .stall_req    (stall_req),
      .misalign     (misalign),
      .bus_err      (bus_err),
      .dbus_req     (dbus_req),
      .dbus_we      (dbus_we),
      .dbus_addr    (dbus_addr),
      .dbus_be      (dbus_be),
      .dbus_wdata   (dbus_wdata),
      .dbus_ack     (dbus_ack),
      .dbus_rdata   (dbus_rdata)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;

   // Expected values, written by the stimulus, read by the compare process.
   logic        chk_en = 1'b0;
   logic        exp_req, exp_stall, exp_mis, exp_berr, exp_we;
   logic [4:0]  exp_waddr;
   logic [31:0] exp_wdata;
   logic        chk_waddr, chk_wdata, chk_dbus, chk_dwdata;
   logic        exp_dwe;
   logic [31:0] exp_daddr, exp_dwdata;
   logic [3:0]  exp_dbe;
   int          ph = 0;  // 1 first BUSY cycle, 2 later BUSY, 3 DONE

   // Snapshots for the literal pins.
   logic        snap_dwe, snap_we, snap_berr;
   logic [31:0] snap_daddr, snap_dwdata, snap_wdata;
   logic [3:0]  snap_dbe;
   int          stall_cnt, mis_cnt, req_cnt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("dbus_req", {31'd0, dbus_req}, {31'd0, exp_req});
         chk("stall_req", {31'd0, stall_req}, {31'd0, exp_stall});
         chk("misalign", {31'd0, misalign}, {31'd0, exp_mis});
         chk("bus_err", {31'd0, bus_err}, {31'd0, exp_berr});
         chk("wb_reg_we", {31'd0, wb_reg_we}, {31'd0, exp_we});
         if (chk_waddr) chk("wb_reg_waddr", {27'd0, wb_reg_waddr}, {27'd0, exp_waddr});
         if (chk_wdata) chk("wb_reg_wdata", wb_reg_wdata, exp_wdata);
         if (chk_dbus) begin
            chk("dbus_we", {31'd0, dbus_we}, {31'd0, exp_dwe});
            chk("dbus_addr", dbus_addr, exp_daddr);
            chk("dbus_be", {28'd0, dbus_be}, {28'd0, exp_dbe});
            if (chk_dwdata) chk("dbus_wdata", dbus_wdata, exp_dwdata);
         end
         if (stall_req) stall_cnt++;
         if (misalign) mis_cnt++;
         if (dbus_req) req_cnt++;
         if (ph == 1) begin
            snap_dwe    = dbus_we;
            snap_daddr  = dbus_addr;
            snap_dbe    = dbus_be;
            snap_dwdata = dbus_wdata;
         end
         if (ph == 3) begin
            snap_wdata = wb_reg_wdata;
            snap_we    = wb_reg_we;
            snap_berr  = bus_err;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Model helpers: plain arithmetic on the RV32I rules
   // ---------------------------------------------------------------------------
   function automatic logic [31:0] load_val(input logic [3:0] op, input logic [31:0] addr,
                                             input logic [31:0] word);
      logic [31:0] b, h;
      b = (word >> (8 * (addr % 4))) & 32'hFF;
      h = (word >> (16 * ((addr / 2) % 2))) & 32'hFFFF;
      case (op)
         4'd1: return (b >= 128) ? b - 32'd256 : b;
         4'd2: return (h >= 32768) ? h - 32'd65536 : h;
         4'd4: return b;
         4'd5: return h;
         default: return word;
      endcase
   endfunction

   function automatic logic [3:0] store_be(input logic [3:0] op, input logic [31:0] addr);
      case (op)
         4'd6: return 4'(1 << (addr % 4));
         4'd7: return 4'(3 << (2 * ((addr / 2) % 2)));
         default: return 4'hF;
      endcase
   endfunction

   function automatic logic [31:0] store_data(input logic [3:0] op, input logic [31:0] sd);
      case (op)
         4'd6: return (sd & 32'hFF) * 32'h0101_0101;
         4'd7: return (sd & 32'hFFFF) * 32'h0001_0001;
         default: return sd;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_exp();
      exp_req = 1'b0; exp_stall = 1'b0; exp_mis = 1'b0; exp_berr = 1'b0; exp_we = 1'b0;
      chk_waddr = 1'b0; chk_wdata = 1'b0; chk_dbus = 1'b0; chk_dwdata = 1'b0;
      ph = 0;
   endtask

   // One op through the stage. ack_at: BUSY cycle index (0-based) carrying the
   // ack, -1 for none. stray: extra ack in IDLE (non-access) or DONE (access).
   task automatic do_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sd,
                        input logic [4:0] waddr, input logic we, input logic [31:0] wdata,
                        input int ack_at, input logic [31:0] rdata, input logic stray);
      bit ld, st, mis, acc, done, err;
      ld  = (op >= 1) && (op <= 5);
      st  = (op >= 6) && (op <= 8);
      mis = ((op == 2 || op == 5 || op == 7) && (addr % 2 != 0)) ||
            ((op == 3 || op == 8) && (addr % 4 != 0));
      acc = (ld || st) && !mis;
      mem_op = op; mem_addr = addr; mem_sdata = sd;
      mem_reg_waddr = waddr; mem_reg_we = we; mem_reg_wdata = wdata;
      stall_cnt = 0; mis_cnt = 0; req_cnt = 0;
      clear_exp();
      exp_waddr = waddr; exp_wdata = wdata;
      if (!acc) begin
         exp_mis   = mis;
         exp_we    = mis ? 1'b0 : we;
         chk_waddr = !mis;
         chk_wdata = !mis;
         dbus_ack  = stray;
         tick();
         dbus_ack = 1'b0;
         return;
      end
      exp_stall = 1'b1;
      tick();
      exp_req    = 1'b1;
      exp_dwe    = st;
      exp_daddr  = addr & 32'hFFFF_FFFC;
      exp_dbe    = store_be(op, addr);
      exp_dwdata = store_data(op, sd);
      chk_dbus   = 1'b1;
      chk_dwdata = st;
      done = 0; err = 0;
      for (int b = 0; b < TO && !done && !err; b++) begin
         ph = (b == 0) ? 1 : 2;
         if (b == ack_at) begin
            dbus_ack = 1'b1; dbus_rdata = rdata;
         end
         tick();
         dbus_ack = 1'b0; dbus_rdata = 32'h0;
         if (b == ack_at) done = 1;
         else if (b == TO - 1) err = 1;
      end
      ph = 3;
      exp_req = 1'b0; exp_stall = 1'b0; chk_dbus = 1'b0; chk_dwdata = 1'b0;
      exp_berr = err; chk_waddr = 1'b1;
      if (err || st) begin
         exp_we = 1'b0;
      end else begin
         exp_we = we; chk_wdata = 1'b1; exp_wdata = load_val(op, addr, rdata);
      end
      dbus_ack = stray; dbus_rdata = 32'h5555_5555;
      tick();
      dbus_ack = 1'b0; dbus_rdata = 32'h0;
      ph = 0;
   endtask

   task automatic expect_all_zero();
      clear_exp();
      exp_waddr = 5'd0; exp_wdata = 32'd0; chk_waddr = 1'b1; chk_wdata = 1'b1;
      exp_dwe = 1'b0; exp_daddr = 32'd0; exp_dbe = 4'd0; exp_dwdata = 32'd0;
      chk_dbus = 1'b1; chk_dwdata = 1'b1;
   endtask

   initial begin
      rst = 1'b1; dbus_ack = 1'b0; dbus_rdata = 32'h0;
      mem_op = 4'd0; mem_addr = 32'h0; mem_sdata = 32'h0;
      // Non-zero pass-through inputs during reset: outputs must still be 0.
      mem_reg_waddr = 5'd3; mem_reg_we = 1'b1; mem_reg_wdata = 32'hAAAA;
      clear_exp();
      tick();
      expect_all_zero();
      chk_en = 1'b1;
      tick();
      rst = 1'b0;

      // ADD pass-through with a stray ack in IDLE; then an undefined op.
      do_op(4'd0, 32'h0, 32'h0, 5'd5, 1'b1, 32'h1234, -1, 32'h0, 1'b1);
      chk("add_req_never", req_cnt, 0);
      do_op(4'd12, 32'h10, 32'h0, 5'd9, 1'b1, 32'h0BAD_F00D, -1, 32'h0, 1'b0);

      // LB 0x1003, ack in the second BUSY cycle.
      do_op(4'd1, 32'h1003, 32'h0, 5'd7, 1'b1, 32'h1003, 1, 32'h80FF_FF00, 1'b0);
      chk("lb_addr", snap_daddr, 32'h1000);
      chk("lb_be", {28'd0, snap_dbe}, 32'hF);
      chk("lb_stall", stall_cnt, 3);
      chk("lb_wdata", snap_wdata, 32'hFFFF_FF80);
      do_op(4'd4, 32'h1003, 32'h0, 5'd7, 1'b1, 32'h1003, 1, 32'h80FF_FF00, 1'b0);
      chk("lbu_wdata", snap_wdata, 32'h0000_0080);

      // SH 0x2002 acked in the first BUSY cycle.
      do_op(4'd7, 32'h2002, 32'hDEAD_BEEF, 5'd4, 1'b1, 32'h2002, 0, 32'h0, 1'b0);
      chk("sh_we", {31'd0, snap_dwe}, 32'd1);
      chk("sh_be", {28'd0, snap_dbe}, 32'hC);
      chk("sh_wdata", snap_dwdata, 32'hBEEF_BEEF);
      chk("sh_wb_we", {31'd0, snap_we}, 32'd0);
      chk("sh_stall", stall_cnt, 2);

      // Misaligned LW, LHU.
      do_op(4'd3, 32'h3001, 32'h0, 5'd6, 1'b1, 32'h3001, -1, 32'h0, 1'b0);
      chk("lw_mis_pulse", mis_cnt, 1);
      chk("lw_mis_req", req_cnt, 0);
      do_op(4'd5, 32'h1001, 32'h0, 5'd6, 1'b1, 32'h1001, -1, 32'h0, 1'b0);

      // Half loads, sign and zero extension.
      do_op(4'd2, 32'h1002, 32'h0, 5'd8, 1'b1, 32'h0, 0, 32'h8001_7FFF, 1'b0);
      chk("lh_wdata", snap_wdata, 32'hFFFF_8001);
      do_op(4'd5, 32'h1000, 32'h0, 5'd8, 1'b1, 32'h0, 0, 32'h8001_7FFF, 1'b0);
      chk("lhu_wdata", snap_wdata, 32'h0000_7FFF);

      // SB with the ack on the final count: ack wins, no bus_err.
      do_op(4'd6, 32'h41, 32'h1234_5678, 5'd2, 1'b1, 32'h41, TO - 1, 32'h0, 1'b0);
      chk("sb_be", {28'd0, snap_dbe}, 32'h2);
      chk("sb_wdata", snap_dwdata, 32'h7878_7878);
      chk("sb_no_err", {31'd0, snap_berr}, 32'd0);

      // SW with no ack: timeout after TO BUSY cycles.
      do_op(4'd8, 32'h50, 32'hCAFE_0001, 5'd1, 1'b1, 32'h50, -1, 32'h0, 1'b0);
      chk("sw_to_stall", stall_cnt, 1 + TO);
      chk("sw_to_req", req_cnt, TO);
      chk("sw_to_err", {31'd0, snap_berr}, 32'd1);

      // LW with a stray ack in DONE.
      do_op(4'd3, 32'h64, 32'h0, 5'd11, 1'b1, 32'h0, 2, 32'h1357_9BDF, 1'b1);
      chk("lw_wdata", snap_wdata, 32'h1357_9BDF);

      // Reset in the second BUSY cycle of an LW.
      mem_op = 4'd3; mem_addr = 32'h70; mem_sdata = 32'h0;
      mem_reg_waddr = 5'd12; mem_reg_we = 1'b1; mem_reg_wdata = 32'h70;
      clear_exp();
      exp_stall = 1'b1;
      tick();
      exp_req = 1'b1;
      tick();
      rst = 1'b1;
      chk_en = 1'b0;
      tick();
      rst = 1'b0;
      mem_op = 4'd0; mem_addr = 32'h0; mem_reg_waddr = 5'd0; mem_reg_we = 1'b0;
      mem_reg_wdata = 32'h0;
      expect_all_zero();
      chk_en = 1'b1;
      tick();
      // A late ack must not produce any writeback or request.
      dbus_ack = 1'b1; dbus_rdata = 32'hFFFF_FFFF;
      tick();
      dbus_ack = 1'b0; dbus_rdata = 32'h0;
      tick();

      // Normal operation resumes from IDLE.
      do_op(4'd3, 32'h80, 32'h0, 5'd13, 1'b1, 32'h0, 0, 32'hCAFE_F00D, 1'b0);
      chk("post_rst_lw", snap_wdata, 32'hCAFE_F00D);
      chk("post_rst_stall", stall_cnt, 2);

      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
